// File: rtl/dip_button_debounce_pkg.sv
// Shared definitions for the DIP/button debounce block: pad idle level and
// the counter-width helper also used by led_debug_mux.
package dip_button_debounce_pkg;

    localparam logic C_PAD_IDLE = 1'b1;

    // Bits needed to hold the values 0 .. value-1 (never less than one bit).
    function automatic int clogb2(input int value);
        int v;
        int r;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dip_button_debounce_bit.sv
// One pad bit: synchroniser chain, stability counter, accepted level and
// registered rise/fall strobes aligned with the level update.
module dip_button_debounce_bit #(
    parameter int C_SYNC_STAGES     = 2,
    parameter int C_DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    import dip_button_debounce_pkg::*;

    localparam int             CNT_W   = clogb2(C_DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_DEBOUNCE_CYCLES - 1);

    logic [C_SYNC_STAGES-1:0] sync_q;
    logic                     synced_s;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     stable_q, stable_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;

    assign synced_s = sync_q[C_SYNC_STAGES-1];

    // Any return to the accepted level discards the partial count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (synced_s == stable_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = {CNT_W{1'b0}};
            stable_d = synced_s;
            rise_d   = synced_s;
            fall_d   = ~synced_s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= {C_SYNC_STAGES{C_PAD_IDLE}};
            cnt_q    <= {CNT_W{1'b0}};
            stable_q <= C_PAD_IDLE;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[C_SYNC_STAGES-2:0], pad_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/dip_button_debounce.sv
// Debounces 4 DIP switches and C_NUM_BUTTONS buttons (all active-low pads).
// Optional auto-repeat on held buttons: define DIP_BUTTON_DEBOUNCE_REPEAT_EN.
module dip_button_debounce #(
    parameter int C_NUM_BUTTONS     = 5,
    parameter int C_SYNC_STAGES     = 2,
    parameter int C_DEBOUNCE_CYCLES = 1000000,
    parameter int C_REPEAT_CYCLES   = 25000000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [3:0]               DIP_IN,
    input  logic [C_NUM_BUTTONS-1:0] BTN_IN,
    output logic [3:0]               DIP_OUT,
    output logic                     DIP_CHANGED,
    output logic [C_NUM_BUTTONS-1:0] BTN_LEVEL,
    output logic [C_NUM_BUTTONS-1:0] BTN_PRESS,
    output logic [C_NUM_BUTTONS-1:0] BTN_RELEASE
);
    import dip_button_debounce_pkg::*;

    localparam int NBITS = 4 + C_NUM_BUTTONS;

    logic [NBITS-1:0]         pads_s;
    logic [NBITS-1:0]         stable_s;
    logic [NBITS-1:0]         rise_s;
    logic [NBITS-1:0]         fall_s;
    logic [C_NUM_BUTTONS-1:0] btn_level_s;
    logic [C_NUM_BUTTONS-1:0] btn_first_press_s;

    assign pads_s = {BTN_IN, DIP_IN};

    for (genvar g = 0; g < NBITS; g++) begin : g_bit
        dip_button_debounce_bit #(
            .C_SYNC_STAGES     (C_SYNC_STAGES),
            .C_DEBOUNCE_CYCLES (C_DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i    (CLK),
            .rst_i    (RST),
            .pad_i    (pads_s[g]),
            .stable_o (stable_s[g]),
            .rise_o   (rise_s[g]),
            .fall_o   (fall_s[g])
        );
    end

    assign DIP_OUT           = stable_s[3:0];
    assign DIP_CHANGED       = |(rise_s[3:0] | fall_s[3:0]);
    assign btn_level_s       = ~stable_s[NBITS-1:4];
    assign btn_first_press_s = fall_s[NBITS-1:4];
    assign BTN_LEVEL         = btn_level_s;
    assign BTN_RELEASE       = rise_s[NBITS-1:4];

`ifdef DIP_BUTTON_DEBOUNCE_REPEAT_EN
    localparam int               RPT_W   = clogb2(C_REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(C_REPEAT_CYCLES - 1);

    logic [RPT_W-1:0]         rpt_cnt_q [C_NUM_BUTTONS];
    logic [C_NUM_BUTTONS-1:0] rpt_hit_s;

    for (genvar b = 0; b < C_NUM_BUTTONS; b++) begin : g_rpt_hit
        assign rpt_hit_s[b] = (rpt_cnt_q[b] == RPT_MAX);
    end

    // Released buttons hold the counter at zero, so a release always wins over a repeat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < C_NUM_BUTTONS; i++) begin
                rpt_cnt_q[i] <= {RPT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < C_NUM_BUTTONS; i++) begin
                if (btn_first_press_s[i] || !btn_level_s[i] || rpt_hit_s[i]) begin
                    rpt_cnt_q[i] <= {RPT_W{1'b0}};
                end else begin
                    rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
                end
            end
        end
    end

    assign BTN_PRESS = btn_first_press_s | (btn_level_s & rpt_hit_s);
`else
    assign BTN_PRESS = btn_first_press_s;
`endif

endmodule
